// File: rtl/split_1_pkg.sv
// split_1 shared definitions: field layout, LFSR taps, FSM states.
// Imported by the predicate, the sampler and the benches.
package split_1_pkg;

    localparam int V0_W = 13;
    localparam int V1_W = 13;
    localparam int V2_W = 14;
    localparam int V3_W = 14;
    localparam int V4_W = 8;

    localparam int V0_LSB = 0;
    localparam int V1_LSB = 13;
    localparam int V2_LSB = 26;
    localparam int V3_LSB = 40;
    localparam int V4_LSB = 54;

    // Feedback taps at bits 63, 62, 60 and 59.
    localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

    // Offset that maps the checker's 0x39DD reference onto 0xE8C3.
    localparam logic [15:0] SAT_OFFSET = 16'hE8C3 - 16'h39DD;

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        HOLD,
        DONE
    } state_e;

    typedef struct packed {
        logic [V4_W-1:0] v4;
        logic [V3_W-1:0] v3;
        logic [V2_W-1:0] v2;
        logic [V1_W-1:0] v1;
        logic [V0_W-1:0] v0;
    } cand_t;

    function automatic logic [63:0] lfsr_step(input logic [63:0] l);
        return {l[62:0], ^(l & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/split_1_pred.sv
// split_1 constraint predicate, purely combinational.
// Fields var_0, var_3 and var_4 are unconstrained but kept on the port.
module split_1_pred
    import split_1_pkg::*;
(
    input  logic [V0_W-1:0] var_0,
    input  logic [V1_W-1:0] var_1,
    input  logic [V2_W-1:0] var_2,
    input  logic [V3_W-1:0] var_3,
    input  logic [V4_W-1:0] var_4,
    output logic            sat
);

    logic        t_nz;
    logic        t_half;
    logic        t_off;
    logic [15:0] off_sum;
    logic        unused_fields;

    // Three conjunct terms; the offset term is kept for checker equivalence.
    always_comb begin
        off_sum = {2'b0, var_2} + SAT_OFFSET;
        t_nz    = (var_1 != '0);
        t_half  = ({1'b0, var_2[V2_W-1:1]} != {1'b0, var_1});
        t_off   = (off_sum != 16'h0);
        sat     = t_nz && t_half && t_off;
    end

    assign unused_fields = ^{var_0, var_3, var_4};

endmodule

// File: rtl/split_1_sampler.sv
// split_1 solution generator: LFSR candidates filtered by split_1_pred,
// streamed out over a valid/ready handshake.
module split_1_sampler
    import split_1_pkg::*;
#(
    parameter int MAX_TRIES = 1024,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [63:0]      seed,
    input  logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [12:0]      var_0,
    output logic [12:0]      var_1,
    output logic [13:0]      var_2,
    output logic [13:0]      var_3,
    output logic [7:0]       var_4,
    output logic             done,
    output logic             fail
);

    localparam int TW = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [TW-1:0] TRY_LAST = TW'(MAX_TRIES - 1);

    state_e           state_q, state_d;
    logic [63:0]      lfsr_q, lfsr_d;
    logic [TW-1:0]    tries_q, tries_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    cand_t            cand_q, cand_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             fail_q, fail_d;

    cand_t cur;
    logic  cur_sat;

    assign cur.v0 = lfsr_q[V0_LSB +: V0_W];
    assign cur.v1 = lfsr_q[V1_LSB +: V1_W];
    assign cur.v2 = lfsr_q[V2_LSB +: V2_W];
    assign cur.v3 = lfsr_q[V3_LSB +: V3_W];
    assign cur.v4 = lfsr_q[V4_LSB +: V4_W];

    split_1_pred u_pred (
        .var_0 (cur.v0),
        .var_1 (cur.v1),
        .var_2 (cur.v2),
        .var_3 (cur.v3),
        .var_4 (cur.v4),
        .sat   (cur_sat)
    );

    // Next-state: FSM transitions, LFSR advance, counters, output regs.
    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        tries_d     = tries_q;
        remaining_d = remaining_q;
        cand_d      = cand_q;
        out_valid_d = out_valid_q;
        fail_d      = fail_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    lfsr_d      = (seed == 64'd0) ? 64'd1 : seed;
                    remaining_d = count;
                    tries_d     = '0;
                    fail_d      = 1'b0;
                    state_d     = (count == '0) ? DONE : SEARCH;
                end
            end
            SEARCH: begin
                lfsr_d = lfsr_step(lfsr_q);
                if (cur_sat) begin
                    cand_d      = cur;
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                end else if (tries_q == TRY_LAST) begin
                    fail_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    tries_d = tries_q + TW'(1);
                end
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    tries_d     = '0;
                    if (remaining_q != '0) begin
                        remaining_d = remaining_q - CNT_W'(1);
                    end
                    state_d = (remaining_q == CNT_W'(1)) ? DONE : SEARCH;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        done_d = (state_d == DONE);
        busy_d = (state_d == SEARCH) || (state_d == HOLD);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            lfsr_q      <= 64'd1;
            tries_q     <= '0;
            remaining_q <= '0;
            cand_q      <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            tries_q     <= tries_d;
            remaining_q <= remaining_d;
            cand_q      <= cand_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            fail_q      <= fail_d;
        end
    end

    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign done      = done_q;
    assign fail      = fail_q;
    assign var_0     = cand_q.v0;
    assign var_1     = cand_q.v1;
    assign var_2     = cand_q.v2;
    assign var_3     = cand_q.v3;
    assign var_4     = cand_q.v4;

endmodule
